decoder: RTL and testbench

- Registered 1-of-9 one-hot decoder for the tic-tac-toe board.
- Converts a binary cell index `sel` (0..8) into nine individual cell enables `en1`..`en9`, one per board square.
- Sits between the move/selection logic and the nine per-cell state registers; only the addressed cell is enabled in a given cycle.

---
 rtl/decoder.sv | 60 ++++++
 tb/tb_decoder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Registered 1-of-9 one-hot cell-enable decoder for the tic-tac-toe board.
// A combinational decode stage feeds a 10-bit register holding {invalid, en9..en1}.
module decoder (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] sel,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic       en8,
    output logic       en9,
    output logic       invalid
);

    // Bit 9 is invalid, bits 8..0 are en9..en1.
    logic [9:0] dec_d;
    logic [9:0] dec_q;

    // The full 9-bit select is compared, so high bits never alias into a cell;
    // unknown selects fall through to the out-of-range default.
    always_comb begin
        dec_d = 10'b10_0000_0000;
        case (sel)
            9'd0:    dec_d = 10'b00_0000_0001;
            9'd1:    dec_d = 10'b00_0000_0010;
            9'd2:    dec_d = 10'b00_0000_0100;
            9'd3:    dec_d = 10'b00_0000_1000;
            9'd4:    dec_d = 10'b00_0001_0000;
            9'd5:    dec_d = 10'b00_0010_0000;
            9'd6:    dec_d = 10'b00_0100_0000;
            9'd7:    dec_d = 10'b00_1000_0000;
            9'd8:    dec_d = 10'b01_0000_0000;
            default: dec_d = 10'b10_0000_0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign en1     = dec_q[0];
    assign en2     = dec_q[1];
    assign en3     = dec_q[2];
    assign en4     = dec_q[3];
    assign en5     = dec_q[4];
    assign en6     = dec_q[5];
    assign en7     = dec_q[6];
    assign en8     = dec_q[7];
    assign en9     = dec_q[8];
    assign invalid = dec_q[9];

endmodule

// File: tb/tb_decoder.sv
// Bench for the registered 1-of-9 decoder: directed steps followed by random selects,
// each compared against an index-based model of the expected cell enables.
module tb_decoder;

    logic       clock;
    logic       reset;
    logic [8:0] sel;
    logic       en1, en2, en3, en4, en5, en6, en7, en8, en9, invalid;

    int errors = 0;
    int checks = 0;

    decoder dut (
        .clock   (clock),
        .reset   (reset),
        .sel     (sel),
        .en1     (en1),
        .en2     (en2),
        .en3     (en3),
        .en4     (en4),
        .en5     (en5),
        .en6     (en6),
        .en7     (en7),
        .en8     (en8),
        .en9     (en9),
        .invalid (invalid)
    );

    initial clock = 1'b0;
    always #100 clock = ~clock;

    function automatic logic [9:0] observed();
        return {invalid, en9, en8, en7, en6, en5, en4, en3, en2, en1};
    endfunction

    // Expected {invalid, en9..en1}: cell index s lights enable s+1, anything else is invalid.
    function automatic logic [9:0] model(input logic r, input logic [8:0] s);
        logic [9:0] e;
        e = '0;
        if (r) return e;
        if ($isunknown(s) || s > 9'd8) begin
            e[9] = 1'b1;
        end else begin
            e[s] = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        logic       inv_ok;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        inv_ok = ($countones(obs[8:0]) <= 1) && !(obs[9] && (|obs[8:0]));
        checks++;
        assert (inv_ok === 1'b1) else begin
            errors++;
            $error("FAIL %s_invariant observed=%b expected=one-hot-or-zero", tag, obs);
        end
    endtask

    // Apply inputs mid-cycle, then check one step after the next rising edge.
    task automatic step(input string tag, input logic r, input logic [8:0] s);
        @(negedge clock);
        reset = r;
        sel   = s;
        @(posedge clock);
        #1;
        check(tag, model(r, s));
    endtask

    initial begin
        logic [8:0] seq [4];
        logic [8:0] oor [4];
        logic [8:0] rs;
        logic       rr;

        reset = 1'b1;
        sel   = 9'd4;

        step("reset0", 1'b1, 9'd4);
        step("reset1", 1'b1, 9'd4);
        step("first_decode", 1'b0, 9'd4);

        for (int i = 0; i <= 8; i++) begin
            step($sformatf("sweep%0d", i), 1'b0, 9'(i));
        end

        oor = '{9'd9, 9'd255, 9'h100, 9'd511};
        for (int i = 0; i < 4; i++) begin
            step($sformatf("oor_%0d", oor[i]), 1'b0, oor[i]);
        end
        step("back_to_0", 1'b0, 9'd0);

        step("reset_x", 1'b1, 9'd0);
        step("sel_x", 1'b0, 9'bx);
        step("after_x", 1'b0, 9'd2);

        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold8_%0d", i), 1'b0, 9'd8);
        end
        step("hold8_reset", 1'b1, 9'd8);
        step("hold8_release", 1'b0, 9'd8);

        seq = '{9'd3, 9'd6, 9'd0, 9'd7};
        for (int i = 0; i < 4; i++) begin
            step($sformatf("b2b_%0d", i), 1'b0, seq[i]);
        end

        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rs = 9'($urandom_range(0, 511));
            end else begin
                rs = 9'($urandom_range(0, 11));
            end
            step($sformatf("rand%0d", i), rr, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
